// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_pkg
// Desc     : Shared constants, controller state encoding and bit-offset
//            helpers for locating a cell inside the puzzle/visibility banks.
// Revision : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int IDX_W   = 7;
  localparam int DIGIT_W = 4;
  localparam int MAP_W   = 4;

  localparam logic [1:0]       VIS_GIVEN = 2'b11;
  localparam logic [IDX_W-1:0] LAST_CELL = 7'd80;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_CHECK  = 3'd3,
    S_SOLVED = 3'd4,
    S_LOST   = 3'd5
  } state_e;

  // Map 0 / cell 0 sits at the top of the bank; later cells step downwards.
  function automatic int map_msb(input int num_maps, input int m, input int c);
    return DIGIT_W * CELLS * num_maps - 1 - DIGIT_W * (CELLS * m + c);
  endfunction

  function automatic int vis_msb(input int num_maps, input int m, input int c);
    return 2 * CELLS * num_maps - 1 - 2 * (CELLS * m + c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sudoku_cell_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_cell_fetch
// Desc     : Combinational lookup of the solution digit and given flag for
//            one cell of the selected puzzle, read straight from the banks.
// Revision : 1.0 - initial release
// ============================================================================
module sudoku_cell_fetch
  import sudoku_pkg::*;
#(
  parameter int NUM_MAPS = 15
) (
  input  logic [DIGIT_W*CELLS*NUM_MAPS-1:0] maps_i,
  input  logic [2*CELLS*NUM_MAPS-1:0]       vis_i,
  input  logic [MAP_W-1:0]                  map_idx_i,
  input  logic [IDX_W-1:0]                  cell_i,
  output logic [DIGIT_W-1:0]                digit_o,
  output logic                              given_o
);

  logic [DIGIT_W-1:0] dig [NUM_MAPS][CELLS];
  logic [1:0]         vis [NUM_MAPS][CELLS];

  // Reshape the flat banks into map/cell arrays so the mux indexes cleanly.
  for (genvar m = 0; m < NUM_MAPS; m++) begin : g_map
    for (genvar c = 0; c < CELLS; c++) begin : g_cell
      assign dig[m][c] = maps_i[map_msb(NUM_MAPS, m, c) -: DIGIT_W];
      assign vis[m][c] = vis_i[vis_msb(NUM_MAPS, m, c) -: 2];
    end
  end

  // Out-of-range cells (write path may see idx>80) read as hidden zero.
  always_comb begin
    digit_o = '0;
    given_o = 1'b0;
    if (cell_i <= LAST_CELL && map_idx_i < MAP_W'(NUM_MAPS)) begin
      digit_o = dig[map_idx_i][cell_i];
      given_o = (vis[map_idx_i][cell_i] == VIS_GIVEN);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sudoku_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_board_ctrl
// Desc     : Game sequencer: picks a puzzle, loads the board one cell per
//            cycle, arbitrates player writes and scans for solved/lost.
// Revision : 1.0 - initial release
// ============================================================================
module sudoku_board_ctrl
  import sudoku_pkg::*;
#(
  parameter int NUM_MAPS     = 15,
  parameter int MAX_MISTAKES = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DIGIT_W*CELLS*NUM_MAPS-1:0] maps_i,
  input  logic [2*CELLS*NUM_MAPS-1:0]       vis_i,
  input  logic                              new_game_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [IDX_W-1:0]                  wr_idx_i,
  input  logic [DIGIT_W-1:0]                wr_val_i,
  output logic                              wr_reject_o,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  output logic [DIGIT_W-1:0]                rd_val_o,
  output logic                              rd_given_o,
  output logic [MAP_W-1:0]                  map_idx_o,
  output logic                              loading_o,
  output logic [1:0]                        mistakes_o,
  output logic                              solved_o,
  output logic                              lost_o
);

  state_e             state_q, state_d;
  logic [MAP_W-1:0]   sel_cnt_q;
  logic [MAP_W-1:0]   map_idx_q, map_idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;       // load pointer in LOAD, scan pointer in CHECK
  logic [1:0]         mistakes_q, mistakes_d;
  logic               all_match_q, all_match_d;
  logic               reject_q, reject_d;
  logic [DIGIT_W-1:0] board_q [CELLS];
  logic [CELLS-1:0]   given_q;

  logic               load_we, play_we;
  logic [DIGIT_W-1:0] ptr_digit, wr_sol_digit;
  logic               ptr_given, wr_given;
  logic               wr_bad, wr_wrong, cell_match;
  logic [1:0]         mistakes_inc;

  sudoku_cell_fetch #(.NUM_MAPS(NUM_MAPS)) u_ptr_fetch (
    .maps_i    (maps_i),
    .vis_i     (vis_i),
    .map_idx_i (map_idx_q),
    .cell_i    (cnt_q),
    .digit_o   (ptr_digit),
    .given_o   (ptr_given)
  );

  sudoku_cell_fetch #(.NUM_MAPS(NUM_MAPS)) u_wr_fetch (
    .maps_i    (maps_i),
    .vis_i     (vis_i),
    .map_idx_i (map_idx_q),
    .cell_i    (wr_idx_i),
    .digit_o   (wr_sol_digit),
    .given_o   (wr_given)
  );

  assign wr_bad       = (wr_idx_i > LAST_CELL) || (wr_val_i > 4'd9) || wr_given;
  assign wr_wrong     = (wr_val_i != '0) && (wr_val_i != wr_sol_digit);
  assign cell_match   = (board_q[cnt_q] == ptr_digit);
  assign mistakes_inc = (mistakes_q == 2'd3) ? 2'd3 : mistakes_q + 2'd1;

  // Next-state and write-enable decode; new_game_i overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    map_idx_d   = map_idx_q;
    mistakes_d  = mistakes_q;
    all_match_d = all_match_q;
    reject_d    = 1'b0;
    load_we     = 1'b0;
    play_we     = 1'b0;
    wr_ready_o  = 1'b0;
    if (new_game_i) begin
      state_d    = S_LOAD;
      cnt_d      = '0;
      map_idx_d  = sel_cnt_q;
      mistakes_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          load_we = 1'b1;
          if (cnt_q == LAST_CELL) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        S_PLAY: begin
          wr_ready_o = 1'b1;
          if (wr_valid_i) begin
            if (wr_bad) begin
              reject_d = 1'b1;
            end else begin
              play_we = 1'b1;
              if (wr_wrong) mistakes_d = mistakes_inc;
              if (mistakes_d == 2'(MAX_MISTAKES)) begin
                state_d = S_LOST;
              end else begin
                state_d = S_CHECK;
                cnt_d   = '0;
              end
            end
          end
        end
        S_CHECK: begin
          all_match_d = ((cnt_q == '0) ? 1'b1 : all_match_q) & cell_match;
          if (cnt_q == LAST_CELL) begin
            state_d = all_match_d ? S_SOLVED : S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers plus the free-running puzzle selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_cnt_q   <= '0;
      map_idx_q   <= '0;
      cnt_q       <= '0;
      mistakes_q  <= '0;
      all_match_q <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_cnt_q   <= (sel_cnt_q == MAP_W'(NUM_MAPS - 1)) ? '0 : sel_cnt_q + 4'd1;
      map_idx_q   <= map_idx_d;
      cnt_q       <= cnt_d;
      mistakes_q  <= mistakes_d;
      all_match_q <= all_match_d;
      reject_q    <= reject_d;
    end
  end

  // Board storage: filled from the bank during LOAD, edited by player writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) board_q[i] <= '0;
      given_q <= '0;
    end else if (load_we) begin
      board_q[cnt_q] <= ptr_given ? ptr_digit : '0;
      given_q[cnt_q] <= ptr_given;
    end else if (play_we) begin
      board_q[wr_idx_i] <= wr_val_i;
    end
  end

  assign rd_val_o    = (rd_idx_i <= LAST_CELL) ? board_q[rd_idx_i] : '0;
  assign rd_given_o  = (rd_idx_i <= LAST_CELL) ? given_q[rd_idx_i] : 1'b0;
  assign map_idx_o   = map_idx_q;
  assign loading_o   = (state_q == S_LOAD);
  assign mistakes_o  = mistakes_q;
  assign solved_o    = (state_q == S_SOLVED);
  assign lost_o      = (state_q == S_LOST);
  assign wr_reject_o = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_board_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sudoku_board_ctrl
// Desc     : Randomized self-checking bench for sudoku_board_ctrl with a
//            board-level game model (random banks, writes, restarts, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sudoku_board_ctrl;

  localparam int NM   = 15;
  localparam int NC   = 81;
  localparam int MAXM = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [4*NC*NM-1:0] maps;
  logic [2*NC*NM-1:0] vis;
  logic               new_game_i, wr_valid_i, wr_ready_o, wr_reject_o;
  logic [6:0]         wr_idx_i, rd_idx_i;
  logic [3:0]         wr_val_i, rd_val_o, map_idx_o;
  logic               rd_given_o, loading_o, solved_o, lost_o;
  logic [1:0]         mistakes_o;

  int n_tests = 0;
  int n_fail  = 0;
  int edges;

  int sol [NM][NC];
  bit giv [NM][NC];
  int m_board [NC];
  int m_map;
  int m_mist;

  sudoku_board_ctrl #(.NUM_MAPS(NM), .MAX_MISTAKES(MAXM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .maps_i      (maps),
    .vis_i       (vis),
    .new_game_i  (new_game_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_idx_i    (wr_idx_i),
    .wr_val_i    (wr_val_i),
    .wr_reject_o (wr_reject_o),
    .rd_idx_i    (rd_idx_i),
    .rd_val_o    (rd_val_o),
    .rd_given_o  (rd_given_o),
    .map_idx_o   (map_idx_o),
    .loading_o   (loading_o),
    .mistakes_o  (mistakes_o),
    .solved_o    (solved_o),
    .lost_o      (lost_o)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: the puzzle selector at the next edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int wrong_val(input int c);
    return (sol[m_map][c] % 9) + 1;
  endfunction

  function automatic int pick_hidden();
    for (int t = 0; t < 1000; t++) begin
      int c;
      c = $urandom_range(0, NC - 1);
      if (!giv[m_map][c]) return c;
    end
    return 1;
  endfunction

  function automatic int pick_given();
    for (int t = 0; t < 1000; t++) begin
      int c;
      c = $urandom_range(0, NC - 1);
      if (giv[m_map][c]) return c;
    end
    return 0;
  endfunction

  task automatic pulse_new_game();
    tick();
    new_game_i = 1'b1;
    m_map = edges % NM;
    tick();
    new_game_i = 1'b0;
    m_mist = 0;
    check("map_idx", 32'(map_idx_o), m_map);
    check("mist_clear", 32'(mistakes_o), 0);
    check("loading_on", 32'(loading_o), 1);
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    while (loading_o && n < 200) begin
      n++;
      tick();
    end
    check("load_len", n, NC);
    check("ready_after_load", 32'(wr_ready_o), 1);
    for (int c = 0; c < NC; c++) m_board[c] = giv[m_map][c] ? sol[m_map][c] : 0;
  endtask

  task automatic check_board();
    for (int c = 0; c < NC; c++) begin
      rd_idx_i = 7'(c);
      #1;
      check("rd_val", 32'(rd_val_o), m_board[c]);
      check("rd_given", 32'(rd_given_o), giv[m_map][c] ? 1 : 0);
    end
    rd_idx_i = 7'($urandom_range(81, 127));
    #1;
    check("rd_oob_val", 32'(rd_val_o), 0);
    check("rd_oob_given", 32'(rd_given_o), 0);
  endtask

  task automatic do_write(input int idx, input int val);
    int  n;
    bit  bad, wrong, all_ok;
    tick();
    n = 0;
    while (!wr_ready_o && n < 300) begin
      n++;
      tick();
    end
    check("ready_before_wr", 32'(wr_ready_o), 1);
    wr_valid_i = 1'b1;
    wr_idx_i   = 7'(idx);
    wr_val_i   = 4'(val);
    tick();
    wr_valid_i = 1'b0;
    bad = (idx > NC - 1) || (val > 9);
    if (!bad) bad = giv[m_map][idx];
    if (bad) begin
      check("reject_pulse", 32'(wr_reject_o), 1);
      check("reject_ready", 32'(wr_ready_o), 1);
      check("reject_mist", 32'(mistakes_o), m_mist);
      tick();
      check("reject_clear", 32'(wr_reject_o), 0);
      return;
    end
    check("no_reject", 32'(wr_reject_o), 0);
    m_board[idx] = val;
    wrong = (val != 0) && (val != sol[m_map][idx]);
    if (wrong && m_mist < 3) m_mist++;
    check("mistakes", 32'(mistakes_o), m_mist);
    rd_idx_i = 7'(idx);
    #1;
    check("rd_after_wr", 32'(rd_val_o), val);
    if (m_mist == MAXM) begin
      check("lost", 32'(lost_o), 1);
      check("lost_ready", 32'(wr_ready_o), 0);
      return;
    end
    n = 0;
    while (!wr_ready_o && !solved_o && n < 300) begin
      n++;
      tick();
    end
    check("scan_len", n, NC);
    all_ok = 1'b1;
    for (int c = 0; c < NC; c++) if (m_board[c] != sol[m_map][c]) all_ok = 1'b0;
    check("solved", 32'(solved_o), all_ok ? 1 : 0);
  endtask

  initial begin
    int hid [$];
    int c, k, w;

    maps = '0;
    vis  = '0;
    for (int m = 0; m < NM; m++) begin
      for (int cc = 0; cc < NC; cc++) begin
        sol[m][cc] = int'($urandom_range(1, 9));
        if (cc == 0)      giv[m][cc] = 1'b1;
        else if (cc == 1) giv[m][cc] = 1'b0;
        else              giv[m][cc] = ($urandom_range(0, 1) == 1);
        maps = {maps[4*NC*NM-5:0], 4'(sol[m][cc])};
        vis  = {vis[2*NC*NM-3:0], giv[m][cc] ? 2'b11 : 2'($urandom_range(0, 2))};
      end
    end

    rst_n = 1'b0; new_game_i = 1'b0; wr_valid_i = 1'b0;
    wr_idx_i = '0; wr_val_i = '0; rd_idx_i = 7'd0;
    repeat (3) tick();
    #1;
    check("rst_loading", 32'(loading_o), 0);
    check("rst_solved", 32'(solved_o), 0);
    check("rst_lost", 32'(lost_o), 0);
    check("rst_mist", 32'(mistakes_o), 0);
    check("rst_ready", 32'(wr_ready_o), 0);
    check("rst_reject", 32'(wr_reject_o), 0);
    check("rst_map", 32'(map_idx_o), 0);
    check("rst_rd_val", 32'(rd_val_o), 0);
    check("rst_rd_given", 32'(rd_given_o), 0);
    tick();
    rst_n = 1'b1;

    // First game: selector still at 0 on the first edge after reset.
    new_game_i = 1'b1;
    m_map = edges % NM;
    tick();
    new_game_i = 1'b0;
    m_mist = 0;
    check("first_map", 32'(map_idx_o), 0);
    check("loading_on", 32'(loading_o), 1);
    wait_load();
    check_board();

    // Rejected writes: given target, index past the board, digit above 9.
    for (k = 0; k < 6; k++) begin
      case (k % 3)
        0:       do_write(pick_given(), $urandom_range(1, 9));
        1:       do_write($urandom_range(81, 127), $urandom_range(0, 9));
        default: do_write(pick_hidden(), $urandom_range(10, 15));
      endcase
    end
    check_board();

    // One correct entry, then wrong entries until the game is lost.
    c = pick_hidden();
    do_write(c, sol[m_map][c]);
    for (k = 0; k < MAXM; k++) begin
      c = pick_hidden();
      do_write(c, wrong_val(c));
    end
    check("lost_final", 32'(lost_o), 1);
    tick();
    c = pick_hidden();
    wr_valid_i = 1'b1; wr_idx_i = 7'(c); wr_val_i = 4'(wrong_val(c));
    #1;
    check("lost_no_ready", 32'(wr_ready_o), 0);
    tick();
    wr_valid_i = 1'b0;
    check("lost_mist_hold", 32'(mistakes_o), MAXM);
    check("lost_hold", 32'(lost_o), 1);
    check_board();

    // Restart in the middle of a scan.
    pulse_new_game();
    wait_load();
    tick();
    c = pick_hidden();
    wr_valid_i = 1'b1; wr_idx_i = 7'(c); wr_val_i = 4'(wrong_val(c));
    tick();
    wr_valid_i = 1'b0;
    check("chk_mist", 32'(mistakes_o), 1);
    repeat (20) tick();
    check("chk_busy", 32'(wr_ready_o), 0);
    pulse_new_game();

    // Restart again at load cell 40.
    repeat (40) tick();
    check("load_mid", 32'(loading_o), 1);
    pulse_new_game();
    wait_load();
    check_board();

    // Solve map 0: one wrong guess, then every hidden cell in random order.
    while (edges % NM != NM - 1) tick();
    pulse_new_game();
    check("solve_map0", 32'(map_idx_o), 0);
    wait_load();
    check_board();
    hid.delete();
    for (int cc = 0; cc < NC; cc++) if (!giv[m_map][cc]) hid.push_back(cc);
    for (int i = hid.size() - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = hid[i]; hid[i] = hid[j]; hid[j] = t;
    end
    do_write(hid[0], wrong_val(hid[0]));
    for (w = 0; w < hid.size(); w++) do_write(hid[w], sol[m_map][hid[w]]);
    check("solved_final", 32'(solved_o), 1);
    tick();
    wr_valid_i = 1'b1; wr_idx_i = 7'(hid[0]); wr_val_i = 4'd0;
    #1;
    check("solved_no_ready", 32'(wr_ready_o), 0);
    tick();
    wr_valid_i = 1'b0;
    check("solved_hold", 32'(solved_o), 1);

    // Asynchronous reset mid-load with a nonzero puzzle latched.
    while (edges % NM != 6) tick();
    pulse_new_game();
    check("pre_rst_map", 32'(map_idx_o), 7);
    repeat (30) tick();
    rd_idx_i = 7'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_loading", 32'(loading_o), 0);
    check("arst_map", 32'(map_idx_o), 0);
    check("arst_mist", 32'(mistakes_o), 0);
    check("arst_ready", 32'(wr_ready_o), 0);
    check("arst_rd_val", 32'(rd_val_o), 0);
    check("arst_rd_given", 32'(rd_given_o), 0);
    check("arst_solved", 32'(solved_o), 0);
    check("arst_lost", 32'(lost_o), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", 32'(loading_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
